div_controller: RTL and testbench

DIV_CONTROLLER -- requirements
Module: div_controller

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 29 ++
 rtl/div_controller.sv | 116 +++++++++++
 tb/tb_div_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM states, operand width,
// iteration count and the operand-magnitude helper.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE,
        DIV_ON,
        DIV_ZERO,
        DIV_END
    } divState_t;

    function automatic logic [DIV_WIDTH-1:0] magnitude(
        input logic [DIV_WIDTH-1:0] value,
        input logic                 isSigned
    );
        return (isSigned && value[DIV_WIDTH-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: brings in the next dividend bit,
// trial-subtracts the divisor and keeps the difference when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   partRem,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisorMag,
    output logic [WIDTH:0]   nextRem,
    output logic [WIDTH-1:0] nextQuo
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             quoBit;

    // quoIn holds the unconsumed dividend bits at the top; the new quotient
    // bit enters at the bottom of nextQuo.
    always_comb begin
        shifted = {partRem, quoIn[WIDTH-1]};
        trial   = shifted - {2'b00, divisorMag};
        quoBit  = ~trial[WIDTH+1];
        nextRem = quoBit ? trial[WIDTH:0] : shifted[WIDTH:0];
        nextQuo = {quoIn[WIDTH-2:0], quoBit};
    end

endmodule

// File: rtl/div_controller.sv
// Multi-cycle DIV/DIVU unit: 32 restoring steps on operand magnitudes,
// sign fix-up on commit, divide-by-zero short path, annul and reset abort.
module div_controller
    import div_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 annul,
    output logic                 busy,
    output logic                 result_valid,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    divState_t            state;
    logic [CNT_WIDTH-1:0] count;
    logic [DIV_WIDTH:0]   partRem;
    logic [DIV_WIDTH-1:0] quoReg;
    logic [DIV_WIDTH-1:0] divisorMag;
    logic                 negQuo;
    logic                 negRem;
    logic [DIV_WIDTH:0]   stepRem;
    logic [DIV_WIDTH-1:0] stepQuo;
    logic [DIV_WIDTH-1:0] finalQuo;
    logic [DIV_WIDTH-1:0] finalRem;

    div_step #(.WIDTH(DIV_WIDTH)) u_step (
        .partRem   (partRem),
        .quoIn     (quoReg),
        .divisorMag(divisorMag),
        .nextRem   (stepRem),
        .nextQuo   (stepQuo)
    );

    // Result of the last step with signs restored, committed on entry to DIV_END.
    always_comb begin
        finalQuo = negQuo ? -stepQuo : stepQuo;
        finalRem = negRem ? -stepRem[DIV_WIDTH-1:0] : stepRem[DIV_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            partRem      <= '0;
            quoReg       <= '0;
            divisorMag   <= '0;
            negQuo       <= 1'b0;
            negRem       <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !annul) begin
                        quoReg     <= magnitude(dividend, signed_div);
                        divisorMag <= magnitude(divisor, signed_div);
                        negQuo     <= signed_div & (dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1]);
                        negRem     <= signed_div & dividend[DIV_WIDTH-1];
                        partRem    <= '0;
                        count      <= '0;
                        busy       <= 1'b1;
                        state      <= (divisor == '0) ? DIV_ZERO : DIV_ON;
                    end
                end
                DIV_ON: begin
                    if (annul) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        partRem <= stepRem;
                        quoReg  <= stepQuo;
                        count   <= count + 1'b1;
                        if (count == CNT_WIDTH'(DIV_ITERS - 1)) begin
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            quotient     <= finalQuo;
                            remainder    <= finalRem;
                            div_by_zero  <= 1'b0;
                            state        <= DIV_END;
                        end
                    end
                end
                DIV_ZERO: begin
                    busy <= 1'b0;
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        result_valid <= 1'b1;
                        quotient     <= '0;
                        remainder    <= '0;
                        div_by_zero  <= 1'b1;
                        state        <= DIV_END;
                    end
                end
                DIV_END: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_controller.sv
// Bench for div_controller: a cycle-level reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_div_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        busy;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    div_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_div  (signed_div),
        .dividend    (dividend),
        .divisor     (divisor),
        .annul       (annul),
        .busy        (busy),
        .result_valid(result_valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of DIV/DIVU, using 64-bit arithmetic so that
    // -2^31 / -1 wraps naturally to 0x80000000.
    function automatic void modelDiv(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0; z = 1'b1;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Transaction-level model: an accepted op owns the unit until its
    // completion cycle, which is fixed by the latency rule.
    int          cyc = 0;
    int          prevCyc;
    int          validCycle = 0;
    bit          active = 0;
    bit          modelReady = 0;
    logic [31:0] expQ, expR, pendQ, pendR;
    logic        expZ, pendZ;

    always @(posedge clk) begin
        prevCyc = cyc;
        cyc     = cyc + 1;
        if (!rst) begin
            active = 0; modelReady = 1;
            expQ = 32'd0; expR = 32'd0; expZ = 1'b0;
        end else if (active) begin
            if (prevCyc == validCycle) active = 0;
            else if (annul) active = 0;
            else if (cyc == validCycle) begin
                expQ = pendQ; expR = pendR; expZ = pendZ;
            end
        end else if (start && !annul) begin
            active = 1;
            validCycle = prevCyc + ((divisor == 32'd0) ? 2 : 33);
            modelDiv(signed_div, dividend, divisor, pendQ, pendR, pendZ);
        end
    end

    always @(negedge clk) begin
        if (modelReady) begin
            chk("busy",         {31'd0, busy},         {31'd0, (active && cyc < validCycle)});
            chk("result_valid", {31'd0, result_valid}, {31'd0, (active && cyc == validCycle)});
            chk("quotient",     quotient,              expQ);
            chk("remainder",    remainder,             expR);
            chk("div_by_zero",  {31'd0, div_by_zero},  {31'd0, expZ});
        end
    end

    task automatic runOp(input string name, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez, input int lat);
        int n;
        bit seen;
        @(posedge clk); #2;
        start = 1'b1; signed_div = sg; dividend = a; divisor = b;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n = n + 1;
            if (result_valid) seen = 1;
        end
        if (!seen) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL %s_timeout: no result_valid within 40 cycles, required latency %0d", name, lat);
        end else begin
            chk({name, "_lat"}, n, lat);
            chk({name, "_q"},   quotient, eq);
            chk({name, "_r"},   remainder, er);
            chk({name, "_z"},   {31'd0, div_by_zero}, {31'd0, ez});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] mq, mr;
        logic        mz;
        int          pulses;
        int          pulseAt;
        logic [31:0] pulseQ, pulseR;

        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        dividend = 32'd0; divisor = 32'd0;

        modelDiv(1'b1, 32'hFFFFFFF9, 32'd2, mq, mr, mz);
        chk("model_s-7/2_q", mq, 32'hFFFFFFFD);
        chk("model_s-7/2_r", mr, 32'hFFFFFFFF);
        modelDiv(1'b1, 32'h80000000, 32'hFFFFFFFF, mq, mr, mz);
        chk("model_min/-1_q", mq, 32'h80000000);
        chk("model_min/-1_z", {31'd0, mz}, 32'd0);

        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);

        runOp("u100/7",      1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 33);
        runOp("s-7/2",       1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33);
        runOp("s7/0",        1'b1, 32'd7,        32'd0,          32'd0,          32'd0,          1'b1, 2);
        runOp("smin/-1",     1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33);
        runOp("umin/max",    1'b0, 32'h80000000, 32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 33);
        runOp("umax/1",      1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33);
        runOp("umax/max",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 33);
        runOp("u5/9",        1'b0, 32'd5,        32'd9,          32'd0,          32'd5,          1'b0, 33);
        runOp("s7/-2",       1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33);
        runOp("s-8/-3",      1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD,   32'd2,          32'hFFFFFFFE,   1'b0, 33);

        // annul in cycle 10 of an operation, new start in cycle 12
        @(posedge clk); #2;
        start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #2 start = 1'b0;
        repeat (9) @(posedge clk);
        #2 annul = 1'b1;
        @(posedge clk); #2 annul = 1'b0;
        @(negedge clk);
        chk("annul_busy", {31'd0, busy}, 32'd0);
        chk("annul_valid", {31'd0, result_valid}, 32'd0);
        chk("annul_q_held", quotient, 32'd2);
        chk("annul_r_held", remainder, 32'hFFFFFFFE);
        runOp("u1000/3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

        // annul during the divide-by-zero cycle
        @(posedge clk); #2;
        start = 1'b1; signed_div = 1'b0; dividend = 32'd5; divisor = 32'd0;
        @(posedge clk); #2 start = 1'b0; annul = 1'b1;
        @(posedge clk); #2 annul = 1'b0;
        @(negedge clk);
        chk("annulz_busy", {31'd0, busy}, 32'd0);
        chk("annulz_flag_held", {31'd0, div_by_zero}, 32'd0);
        chk("annulz_q_held", quotient, 32'd333);

        // start together with annul in IDLE is ignored
        @(posedge clk); #2;
        start = 1'b1; annul = 1'b1; dividend = 32'd40; divisor = 32'd4;
        @(posedge clk); #2 start = 1'b0; annul = 1'b0;
        @(negedge clk);
        chk("startannul_busy", {31'd0, busy}, 32'd0);

        // annul coinciding with the DIV_END cycle still yields the pulse
        @(posedge clk); #2;
        start = 1'b1; signed_div = 1'b0; dividend = 32'd9; divisor = 32'd4;
        @(posedge clk); #2 start = 1'b0;
        repeat (32) @(posedge clk);
        #2 annul = 1'b1;
        @(negedge clk);
        chk("endannul_valid", {31'd0, result_valid}, 32'd1);
        chk("endannul_q", quotient, 32'd2);
        chk("endannul_r", remainder, 32'd1);
        @(posedge clk); #2 annul = 1'b0;

        // a start while busy is ignored; exactly one result appears
        @(posedge clk); #2;
        start = 1'b1; signed_div = 1'b0; dividend = 32'd1000000; divisor = 32'd37;
        @(posedge clk); #2 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #2 start = 1'b0;
        pulses = 0; pulseAt = 0; pulseQ = 32'd0; pulseR = 32'd0;
        for (int i = 6; i < 46; i++) begin
            @(negedge clk);
            if (result_valid) begin
                pulses = pulses + 1; pulseAt = i; pulseQ = quotient; pulseR = remainder;
            end
        end
        chk("busystart_pulses", pulses, 32'd1);
        chk("busystart_lat", pulseAt, 32'd33);
        chk("busystart_q", pulseQ, 32'd27027);
        chk("busystart_r", pulseR, 32'd1);

        // reset in cycle 20 of an operation
        @(posedge clk); #2;
        start = 1'b1; signed_div = 1'b0; dividend = 32'hFFFFFFFF; divisor = 32'd3;
        @(posedge clk); #2 start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, result_valid}, 32'd0);
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        chk("midrst_z", {31'd0, div_by_zero}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid) pulses = pulses + 1;
        end
        chk("midrst_no_pulse", pulses, 32'd0);

        runOp("after_rst_u9/4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 33);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
